mod4051_seq_reducer: RTL
========================

MOD4051_SEQ_REDUCER -- requirements
Module: mod4051_seq_reducer

Interface
REQ-001 SHALL have parameter P, default 4051, the modulus.
REQ-002 SHALL have parameter CHUNK_W, default 6, the operand chunk width.
REQ-003 SHALL have parameter RES_W, default 12, the residue width.
REQ-004 SHALL have parameter MAX_CHUNKS, default 84, the maximum chunks per operand (500-bit operand).
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port start, input, 1, the pulse that begins an operation; sampled only in IDLE.
REQ-008 SHALL have port num_chunks, input, 7, the chunk count latched on accepted start.
REQ-009 SHALL have port in_valid, input, 1, the chunk-valid signal.
REQ-010 SHALL have port in_chunk, input, CHUNK_W, the operand chunk, MSB chunk first.
REQ-011 SHALL have port in_ready, output, 1, the chunk-accept signal.
REQ-012 SHALL have port out_valid, output, 1, the result-valid signal.
REQ-013 SHALL have port out_res, output, RES_W, the operand mod P.
REQ-014 SHALL have port out_ready, input, 1, the result-consume signal.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT, DBL, ADD and DONE.
REQ-017 SHALL, in IDLE with start=1, clear the accumulator to 0, latch min(num_chunks, MAX_CHUNKS) into the remaining count, and go to WAIT, or go to DONE when that count is 0.
REQ-018 SHALL drive in_ready=1 only in WAIT; a chunk is accepted when in_valid&&in_ready, latched, and the FSM goes to DBL.
REQ-019 SHALL, in DBL, set acc=(2*acc) mod P, computed as 13-bit 2*acc minus P if the result is >=P, for exactly 6 consecutive cycles, then go to ADD.
REQ-020 SHALL, in ADD, set acc=(acc+chunk) mod P with one conditional subtract, decrement the remaining count, and go to WAIT if it is nonzero, else to DONE.
REQ-021 SHALL accept chunks no faster than one per 8 cycles (WAIT + 6 DBL + ADD); in_valid low in WAIT stalls indefinitely with no state change.
REQ-022 SHALL keep acc within [0, P-1] at all times, so that each step needs at most one subtract.
REQ-023 SHALL, in DONE, hold out_valid=1 with out_res=acc stable until out_ready=1, then return to IDLE on that edge.
REQ-024 SHALL ignore start outside IDLE.
REQ-025 SHALL ignore in_valid outside WAIT.

Reset
REQ-026 SHALL, on asserted rst_n, asynchronously force state=IDLE, acc=0, count=0, in_ready=0, out_valid=0, out_res=0 and busy=0, including mid-operation; a partial operand is discarded.
REQ-027 SHALL register all outputs, with none driven combinationally from inputs.

Configuration
REQ-028 SHALL, when MOD4051_ABORT_EN is defined, add input abort (1 bit): abort=1 in any non-IDLE state returns to IDLE next edge, clears acc, drops out_valid; no result produced.
REQ-029 SHALL, when MOD4051_ABORT_EN is undefined, have no abort port and only rst_n can terminate an operation.

Structure
REQ-030 SHALL place P, CHUNK_W, RES_W, MAX_CHUNKS and the state enum type in shared package mod4051_pkg.
REQ-031 SHALL use one combinational sub-module mod4051_addsub (a+b mod P, inputs <P) for both the DBL step (a=b=acc) and the ADD step (a=acc, b=zero-extended chunk).

Verification
REQ-032 SHALL verify: start, num_chunks=1, chunk 63 -> out_res=63, out_valid 9 cycles after start.
REQ-033 SHALL verify: num_chunks=3, chunks [1,0,0] (4096) -> out_res=45; chunks [63,63] with num_chunks=2 (4095) -> 44.
REQ-034 SHALL verify: num_chunks=0 -> DONE next cycle with out_res=0; num_chunks=100 -> exactly 84 chunks accepted.
REQ-035 SHALL verify: out_ready held low 20 cycles in DONE -> out_valid and out_res stable; start during that time ignored.
REQ-036 SHALL verify: rst_n low during DBL of chunk 5 -> all outputs 0 immediately, next operation with random 84 chunks matches the software model (operand mod 4051).
REQ-037 SHALL verify, with MOD4051_ABORT_EN: abort in WAIT -> IDLE next cycle, busy=0, no out_valid pulse.

Source files
------------

// File: rtl/mod4051_pkg.sv
// Shared constants and FSM state type for the mod-4051 sequential reducer.
package mod4051_pkg;

  localparam int P          = 4051;
  localparam int CHUNK_W    = 6;
  localparam int RES_W      = 12;
  localparam int MAX_CHUNKS = 84;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DBL,
    ADD,
    DONE
  } state_e;

endpackage

// File: rtl/mod4051_addsub.sv
// Combinational modular adder: sum = (a + b) mod P, valid when a, b < P.
module mod4051_addsub #(
  parameter int P     = mod4051_pkg::P,
  parameter int RES_W = mod4051_pkg::RES_W
) (
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] sum
);

  logic [RES_W:0] raw;

  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    if (raw >= (RES_W+1)'(P)) begin
      sum = RES_W'(raw - (RES_W+1)'(P));
    end else begin
      sum = RES_W'(raw);
    end
  end

endmodule

// File: rtl/mod4051_seq_reducer.sv
// Streams an operand MSB-chunk-first and reduces it mod P by Horner steps
// (6 modular doublings then one modular add per chunk). Optional MOD4051_ABORT_EN adds an abort input.
module mod4051_seq_reducer #(
  parameter int P          = mod4051_pkg::P,
  parameter int CHUNK_W    = mod4051_pkg::CHUNK_W,
  parameter int RES_W      = mod4051_pkg::RES_W,
  parameter int MAX_CHUNKS = mod4051_pkg::MAX_CHUNKS
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef MOD4051_ABORT_EN
  input  logic               abort,
`endif
  input  logic               start,
  input  logic [6:0]         num_chunks,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] in_chunk,
  output logic               in_ready,
  output logic               out_valid,
  output logic [RES_W-1:0]   out_res,
  input  logic               out_ready,
  output logic               busy
);

  import mod4051_pkg::*;

  localparam int DBL_W = $clog2(CHUNK_W) + 1;

  state_e             state, state_n;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   addsub_b;
  logic [RES_W-1:0]   addsub_sum;
  logic [CHUNK_W-1:0] chunk_q;
  logic [6:0]         count;
  logic [6:0]         cnt_init;
  logic [DBL_W-1:0]   dbl_cnt;
  logic               abort_req;
  logic               in_ready_d;
  logic               out_valid_d;
  logic               busy_d;

`ifdef MOD4051_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign cnt_init = (num_chunks > 7'(MAX_CHUNKS)) ? 7'(MAX_CHUNKS) : num_chunks;

  // One adder serves both steps: DBL adds acc to itself, ADD adds the chunk.
  assign addsub_b = (state == ADD) ? {{(RES_W-CHUNK_W){1'b0}}, chunk_q} : acc;

  mod4051_addsub #(
    .P     (P),
    .RES_W (RES_W)
  ) u_addsub (
    .a   (acc),
    .b   (addsub_b),
    .sum (addsub_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = (cnt_init == '0) ? DONE : WAIT;
      WAIT:    if (in_valid) state_n = DBL;
      DBL:     if (dbl_cnt == DBL_W'(CHUNK_W - 1)) state_n = ADD;
      ADD:     state_n = (count == 7'd1) ? DONE : WAIT;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_req) state_n = IDLE;
  end

  // Outputs are decoded from the next state and registered, so they align with state.
  always_comb begin
    in_ready_d  = (state_n == WAIT);
    out_valid_d = (state_n == DONE);
    busy_d      = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      count   <= '0;
      chunk_q <= '0;
      dbl_cnt <= '0;
    end else if (abort_req) begin
      acc   <= '0;
      count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            count <= cnt_init;
          end
        end
        WAIT: begin
          if (in_valid) begin
            chunk_q <= in_chunk;
            dbl_cnt <= '0;
          end
        end
        DBL: begin
          acc     <= addsub_sum;
          dbl_cnt <= dbl_cnt + DBL_W'(1);
        end
        ADD: begin
          acc   <= addsub_sum;
          count <= count - 7'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_res = acc;

endmodule
